// File: rtl/sodor_instr_gen.sv
// Deterministic RV32I instruction source for the sodor5 harness: a warm-up run of NOPs,
// then R-type / I-type ALU / load words encoded from a Galois LFSR over valid/ready.
module sodor_instr_gen #(
  parameter logic [31:0] SEED   = 32'h000001B9,
  parameter int unsigned WARMUP = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  mode,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [15:0] count
);

  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam int          WW       = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WW-1:0] WARM_INIT = WW'(WARMUP);

  logic [31:0]   lfsr, lfsr_d, lfsr_adv;
  logic [WW-1:0] warm, warm_dec, warm_d;
  logic [31:0]   instr_d;
  logic          valid_d;
  logic [15:0]   count_d;
  logic          fire, load;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  function automatic logic [31:0] encode(input logic [31:0] s, input logic [1:0] m);
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm, imm_i;
    logic [1:0]  cls;
    rd  = s[4:0];
    rs1 = s[9:5];
    rs2 = s[14:10];
    f3  = s[17:15];
    imm = s[29:18];
    // Shift immediates are trimmed to legal shamt/funct7 patterns (srai keeps bit 10).
    case (f3)
      3'd5:    imm_i = imm & 12'h41F;
      3'd1:    imm_i = imm & 12'h01F;
      default: imm_i = imm;
    endcase
    if (m == 2'd3) begin
      case (s[31:30])
        2'd2:    cls = 2'd1;
        2'd3:    cls = 2'd2;
        default: cls = 2'd0;
      endcase
    end else begin
      cls = m;
    end
    case (cls)
      2'd0:    encode = {7'd0, rs2, rs1, f3, rd, 7'b0110011};
      2'd1:    encode = {imm_i, rs1, f3, rd, 7'b0010011};
      default: encode = {imm, rs1, {f3[2], 2'b00}, rd, 7'b0000011};
    endcase
  endfunction

  always_comb begin
    fire     = instr_valid & instr_ready;
    load     = en & (~instr_valid | fire);
    // While warm is nonzero the held word is always a NOP, so any fire retires one.
    warm_dec = (fire && (warm != '0)) ? (warm - WW'(1)) : warm;
    lfsr_adv = lfsr_next(lfsr);

    lfsr_d  = lfsr;
    warm_d  = warm_dec;
    instr_d = instr;
    valid_d = instr_valid;
    count_d = (fire && (count != 16'hFFFF)) ? (count + 16'd1) : count;

    if (load) begin
      valid_d = 1'b1;
      if (warm_dec != '0) begin
        instr_d = NOP;
      end else begin
        lfsr_d  = lfsr_adv;
        instr_d = encode(lfsr_adv, mode);
      end
    end else if (fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr        <= SEED_EFF;
      warm        <= WARM_INIT;
      instr       <= NOP;
      instr_valid <= 1'b0;
      count       <= 16'd0;
    end else begin
      lfsr        <= lfsr_d;
      warm        <= warm_d;
      instr       <= instr_d;
      instr_valid <= valid_d;
      count       <= count_d;
    end
  end

endmodule

// File: tb/tb_sodor_instr_gen.sv
// Directed bench for sodor_instr_gen: reset, warm-up, all classes, backpressure,
// enable drop, shift legality over a long I-type run, and mid-stream reset.
module tb_sodor_instr_gen;

  logic        clk = 1'b0;
  logic        reset, en, instr_ready;
  logic [1:0]  mode;
  logic        instr_valid, instr_valid0;
  logic [31:0] instr, instr0;
  logic [15:0] count, count0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sodor_instr_gen #(.SEED(32'h1), .WARMUP(3)) u_dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .count(count)
  );

  // Zero seed falls back to 1; no warm-up means the first word is random.
  sodor_instr_gen #(.SEED(32'h0), .WARMUP(0)) u_dut0 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .instr_valid(instr_valid0), .instr_ready(instr_ready),
    .instr(instr0), .count(count0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference LFSR and I-type encoder for the long run.
  function automatic logic [31:0] m_next(input logic [31:0] s);
    logic [31:0] t;
    t = {1'b0, s[31:1]};
    if (s[0]) t = t ^ 32'h80200003;
    return t;
  endfunction

  function automatic logic [31:0] m_enc_i(input logic [31:0] s);
    logic [11:0] imm;
    imm = s[29:18];
    if (s[17:15] == 3'd1) imm = {7'd0, imm[4:0]};
    if (s[17:15] == 3'd5) imm = {1'b0, imm[10], 5'd0, imm[4:0]};
    return {imm, s[9:5], s[17:15], s[4:0], 7'b0010011};
  endfunction

  // Reset, run the three NOPs, stop with the first random word held.
  task automatic restart(input logic [1:0] m, input logic [31:0] first_exp, input string tag);
    reset = 1'b1; en = 1'b1; instr_ready = 1'b1; mode = m;
    step();
    reset = 1'b0;
    step();
    check({tag, "_nop1"}, instr, 32'h00000013);
    step();
    step();
    check({tag, "_nop3"}, instr, 32'h00000013);
    step();
    check({tag, "_first"}, instr, first_exp);
  endtask

  initial begin
    logic [31:0] ml;
    logic [11:0] imm;
    logic [2:0]  f3;

    reset = 1'b1; en = 1'b1; mode = 2'd0; instr_ready = 1'b1;
    step(); step(); step();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h00000013);
    check("rst_count", 32'(count), 32'd0);

    reset = 1'b0;
    step();
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_nop", instr, 32'h00000013);
    check("nowarm_valid", 32'(instr_valid0), 32'd1);
    check("nowarm_first", instr0, 32'h000001B3);
    step();
    check("nop2", instr, 32'h00000013);
    check("cnt1", 32'(count), 32'd1);
    check("nowarm_second", instr0, 32'h00000133);
    step();
    check("nop3", instr, 32'h00000013);
    step();
    check("r_first", instr, 32'h000001B3);
    check("cnt3", 32'(count), 32'd3);
    step();
    check("r_second", instr, 32'h00000133);
    check("cnt4", 32'(count), 32'd4);

    // Backpressure, with mode wiggled to show the held word ignores it.
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mode = 2'(i);
      step();
      check("bp_instr", instr, 32'h00000133);
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_count", 32'(count), 32'd4);
    end
    mode = 2'd0; instr_ready = 1'b1;
    step();
    check("bp_resume", instr, 32'h000000B3);
    check("bp_cnt5", 32'(count), 32'd5);

    en = 1'b0;
    step();
    check("en0_valid", 32'(instr_valid), 32'd0);
    check("en0_hold", instr, 32'h000000B3);
    check("en0_cnt", 32'(count), 32'd6);
    step();
    check("en0_idle", 32'(instr_valid), 32'd0);
    check("en0_cnt_idle", 32'(count), 32'd6);

    restart(2'd1, 32'h00800193, "itype");
    step();
    check("itype_2", instr, 32'h00C00113);
    restart(2'd2, 32'h00800183, "load");
    step();
    check("load_2", instr, 32'h00C00103);
    restart(2'd3, 32'h00800193, "mix");
    step();
    check("mix_2_load", instr, 32'h00C00103);
    step();
    check("mix_3_r", instr, 32'h000000B3);

    // Long I-type run against the reference model plus shift-immediate legality.
    restart(2'd1, 32'h00800193, "long");
    ml = 32'h80200003;
    for (int i = 0; i < 1000; i++) begin
      step();
      ml = m_next(ml);
      check("long_word", instr, m_enc_i(ml));
      f3  = instr[14:12];
      imm = instr[31:20];
      if (f3 == 3'd1 || f3 == 3'd5)
        check("shift_imm", 32'(imm & ~12'h41F), 32'd0);
      if (f3 == 3'd1)
        check("slli_b10", 32'(imm[10]), 32'd0);
    end

    // Mid-stream reset.
    restart(2'd0, 32'h000001B3, "mid");
    for (int i = 0; i < 20; i++) step();
    check("mid_cnt", 32'(count), 32'd23);
    reset = 1'b1;
    step();
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_cnt", 32'(count), 32'd0);
    reset = 1'b0;
    step();
    check("mid_nop1", instr, 32'h00000013);
    check("mid_nop1_v", 32'(instr_valid), 32'd1);
    step(); step();
    check("mid_nop3", instr, 32'h00000013);
    step();
    check("mid_first", instr, 32'h000001B3);
    check("mid_cnt3", 32'(count), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
